// File: rtl/data_ram_responder_pkg.sv
// Shared bus widths, responder FSM encodings and defaults for the MEM-stage
// data RAM.
package data_ram_responder_pkg;

  localparam int DATA_BUS    = 32;
  localparam int ADDR_BUS    = 32;
  localparam int MEM_SEL_BUS = 4;

  localparam int DEFAULT_WAIT_STATES = 1;

  typedef enum logic [1:0] {
    RAM_ST_IDLE = 2'd0,
    RAM_ST_BUSY = 2'd1,
    RAM_ST_DONE = 2'd2
  } ram_state_e;

endpackage

// File: rtl/data_ram_bank.sv
// Word-organised data RAM built from four byte-wide synchronous arrays so each
// lane maps onto its own block RAM with a registered read port.
import data_ram_responder_pkg::*;

module data_ram_bank #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MEM_SEL_BUS-1:0] we,
  input  logic                   re,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_BUS-1:0]    wdata,
  output logic [DATA_BUS-1:0]    rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  for (genvar i = 0; i < MEM_SEL_BUS; i++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_byte;

    always_ff @(posedge clk) begin
      if (we[i]) begin
        r_mem[addr] <= wdata[8*i +: 8];
      end
    end

    // The output register only loads on a read commit, so it holds between reads.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_byte <= 8'd0;
      end else if (re) begin
        r_byte <= r_mem[addr];
      end
    end
  end

  assign rdata = {g_lane[3].r_byte, g_lane[2].r_byte, g_lane[1].r_byte, g_lane[0].r_byte};

endmodule

// File: rtl/data_ram_responder.sv
// MEM-stage RAM responder: accepts one request in IDLE, waits WAIT_STATES
// cycles, commits the byte-lane write or word read, then pulses ram_ready.
import data_ram_responder_pkg::*;

module data_ram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ram_en,
  input  logic [MEM_SEL_BUS-1:0] ram_write_en,
  input  logic [ADDR_BUS-1:0]    ram_addr,
  input  logic [DATA_BUS-1:0]    ram_write_data,
  output logic [DATA_BUS-1:0]    ram_read_data,
  output logic                   ram_ready,
  output logic                   stall_req
);

  localparam int              WS_M1   = (WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0;
  localparam logic [3:0]      WS_INIT = 4'(WS_M1);

  ram_state_e             r_state;
  ram_state_e             w_next_state;
  logic [3:0]             r_cnt;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [MEM_SEL_BUS-1:0] r_we;
  logic [DATA_BUS-1:0]    r_wdata;
  logic                   r_ready;

  logic                   w_accept;
  logic                   w_commit;
  logic [ADDR_WIDTH-1:0]  w_c_addr;
  logic [MEM_SEL_BUS-1:0] w_c_we;
  logic [DATA_BUS-1:0]    w_c_wdata;
  logic [MEM_SEL_BUS-1:0] w_bank_we;
  logic                   w_bank_re;
  logic                   w_unused_addr;

  assign w_unused_addr = &{ram_addr[1:0], ram_addr[ADDR_BUS-1:ADDR_WIDTH+2]};

  // With zero wait states the commit happens on the accept edge from the live inputs.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    w_c_addr     = r_addr;
    w_c_we       = r_we;
    w_c_wdata    = r_wdata;
    case (r_state)
      RAM_ST_IDLE: begin
        if (ram_en) begin
          w_accept = 1'b1;
          if (WAIT_STATES == 0) begin
            w_next_state = RAM_ST_DONE;
            w_commit     = 1'b1;
            w_c_addr     = ram_addr[ADDR_WIDTH+1:2];
            w_c_we       = ram_write_en;
            w_c_wdata    = ram_write_data;
          end else begin
            w_next_state = RAM_ST_BUSY;
          end
        end else begin
          w_next_state = RAM_ST_IDLE;
        end
      end
      RAM_ST_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_next_state = RAM_ST_DONE;
          w_commit     = 1'b1;
        end else begin
          w_next_state = RAM_ST_BUSY;
        end
      end
      RAM_ST_DONE: w_next_state = RAM_ST_IDLE;
      default:     w_next_state = RAM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RAM_ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_we    <= 4'd0;
      r_wdata <= 32'd0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ready <= (w_next_state == RAM_ST_DONE);
      if (w_accept) begin
        r_addr  <= ram_addr[ADDR_WIDTH+1:2];
        r_we    <= ram_write_en;
        r_wdata <= ram_write_data;
        r_cnt   <= WS_INIT;
      end else if ((r_state == RAM_ST_BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign w_bank_we = w_commit ? w_c_we : 4'b0000;
  assign w_bank_re = w_commit & (w_c_we == 4'b0000);

  data_ram_bank #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (w_bank_we),
    .re    (w_bank_re),
    .addr  (w_c_addr),
    .wdata (w_c_wdata),
    .rdata (ram_read_data)
  );

  assign ram_ready = r_ready;
  assign stall_req = ram_en & ~r_ready & ~rst;

endmodule
